// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle control unit: opcode values,
// state encoding and ALU operation codes.
package mc_pkg;

  localparam logic [3:0] OP_RTYPE = 4'd0;
  localparam logic [3:0] OP_ADDI  = 4'd1;
  localparam logic [3:0] OP_LW    = 4'd2;
  localparam logic [3:0] OP_SW    = 4'd3;
  localparam logic [3:0] OP_BEQ   = 4'd4;
  localparam logic [3:0] OP_JMP   = 4'd5;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_FAULT  = 3'd7
  } state_e;

  // Opcodes 0110..1111 are undefined.
  function automatic logic op_legal(input logic [3:0] op);
    return (op <= OP_JMP);
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control-unit <-> datapath signal bundle. The master side is the control
// unit; the slave side is the datapath. Performance counter outputs exist
// only when MC_PERF_CNT_EN is defined.
interface multicycle_control_if;

  logic [3:0] opcode;
  logic       mem_ready;
  logic       pc_en;
  logic       ir_en;
  logic       reg_dst;
  logic       beq;
  logic       reg_write;
  logic       jump;
  logic       alu_src;
  logic       mem_to_reg;
  logic       mem_read;
  logic       mem_write;
  logic [1:0] alu_op;
  logic       illegal;
  logic       fault;
  logic [2:0] state;
`ifdef MC_PERF_CNT_EN
  logic [31:0] cyc_cnt;
  logic [31:0] instr_cnt;
`endif

  modport master (
    input  opcode, mem_ready,
    output pc_en, ir_en, reg_dst, beq, reg_write, jump, alu_src,
           mem_to_reg, mem_read, mem_write, alu_op, illegal, fault, state
`ifdef MC_PERF_CNT_EN
    , output cyc_cnt, instr_cnt
`endif
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_en, ir_en, reg_dst, beq, reg_write, jump, alu_src,
           mem_to_reg, mem_read, mem_write, alu_op, illegal, fault, state
`ifdef MC_PERF_CNT_EN
    , input cyc_cnt, instr_cnt
`endif
  );

endinterface

// File: rtl/mc_wait_timer.sv
// Counts MEM wait cycles; expired flags that the wait limit has been reached.
// The count saturates at the limit so it can never wrap.
module mc_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned TMR_W       = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam logic [TMR_W-1:0] LIMIT = TMR_W'(MEM_TIMEOUT);

  logic [TMR_W-1:0] cnt_q, cnt_d;

  // Next count: clear dominates, otherwise advance while counting below the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control unit: sequences FETCH/DECODE/EXEC/MEM/WB strobes for the
// 16-bit datapath, waits on mem_ready in MEM and traps to a sticky FAULT state
// on memory timeout. Optional macro MC_PERF_CNT_EN adds cycle/instruction
// counters.
module multicycle_control
  import mc_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned TMR_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  multicycle_control_if.master bus
);

  state_e     state_q, state_d;
  logic [3:0] op_q, op_d;

  logic       tmr_clear, tmr_count, tmr_expired;

  logic       pc_en, ir_en, reg_dst, beq, reg_write, jump;
  logic       alu_src, mem_to_reg, mem_read, mem_write, illegal, fault;
  logic [1:0] alu_op;
  logic       dec_alu_src;
  logic [1:0] dec_alu_op;

  // The wait counter only runs while MEM is waiting; any other cycle clears it.
  assign tmr_count = (state_q == S_MEM) && !bus.mem_ready;
  assign tmr_clear = (state_q != S_MEM) || bus.mem_ready;

  mc_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .TMR_W      (TMR_W)
  ) u_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (tmr_clear),
    .count  (tmr_count),
    .expired(tmr_expired)
  );

  // State and latched opcode registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // ALU setting for the latched opcode, held from EXEC through WB.
  always_comb begin
    dec_alu_src = 1'b0;
    dec_alu_op  = ALU_ADD;
    case (op_q)
      OP_RTYPE:              dec_alu_op  = ALU_FUNCT;
      OP_ADDI, OP_LW, OP_SW: dec_alu_src = 1'b1;
      OP_BEQ:                dec_alu_op  = ALU_SUB;
      default:               ;
    endcase
  end

  // Next-state and strobe decode.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    pc_en      = 1'b0;
    ir_en      = 1'b0;
    reg_dst    = 1'b0;
    beq        = 1'b0;
    reg_write  = 1'b0;
    jump       = 1'b0;
    alu_src    = 1'b0;
    mem_to_reg = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    alu_op     = ALU_ADD;
    illegal    = 1'b0;
    fault      = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_en   = 1'b1;
        state_d = S_DECODE;
      end
      // The IR was loaded at the end of FETCH, so the opcode input is stable
      // here; it is decoded directly and captured into op_q for later states.
      S_DECODE: begin
        op_d = bus.opcode;
        if (bus.opcode == OP_JMP) begin
          jump    = 1'b1;
          pc_en   = 1'b1;
          state_d = S_FETCH;
        end else if (!op_legal(bus.opcode)) begin
          illegal = 1'b1;
          pc_en   = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_src = dec_alu_src;
        alu_op  = dec_alu_op;
        case (op_q)
          OP_RTYPE, OP_ADDI: state_d = S_WB;
          OP_LW, OP_SW:      state_d = S_MEM;
          OP_BEQ: begin
            beq     = 1'b1;
            pc_en   = 1'b1;
            state_d = S_FETCH;
          end
          default:           state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        alu_src   = dec_alu_src;
        alu_op    = dec_alu_op;
        mem_read  = (op_q == OP_LW);
        mem_write = (op_q == OP_SW);
        if (bus.mem_ready) begin
          if (op_q == OP_SW) begin
            pc_en   = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (tmr_expired) begin
          state_d = S_FAULT;
        end
      end
      S_WB: begin
        alu_src    = dec_alu_src;
        alu_op     = dec_alu_op;
        reg_write  = 1'b1;
        pc_en      = 1'b1;
        reg_dst    = (op_q == OP_RTYPE);
        mem_to_reg = (op_q == OP_LW);
        state_d    = S_FETCH;
      end
      S_FAULT: begin
        fault = 1'b1;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Output drive; everything reads as zero while reset is held.
  always_comb begin
    bus.pc_en      = pc_en      & ~rst;
    bus.ir_en      = ir_en      & ~rst;
    bus.reg_dst    = reg_dst    & ~rst;
    bus.beq        = beq        & ~rst;
    bus.reg_write  = reg_write  & ~rst;
    bus.jump       = jump       & ~rst;
    bus.alu_src    = alu_src    & ~rst;
    bus.mem_to_reg = mem_to_reg & ~rst;
    bus.mem_read   = mem_read   & ~rst;
    bus.mem_write  = mem_write  & ~rst;
    bus.alu_op     = rst ? '0 : alu_op;
    bus.illegal    = illegal    & ~rst;
    bus.fault      = fault      & ~rst;
    bus.state      = rst ? '0 : state_q;
  end

`ifdef MC_PERF_CNT_EN
  logic [31:0] cyc_q, cyc_d, instr_q, instr_d;

  // Cycle counter freezes in FAULT; instruction counter tracks PC loads.
  always_comb begin
    cyc_d   = (state_q != S_FAULT) ? cyc_q + 32'd1 : cyc_q;
    instr_d = pc_en ? instr_q + 32'd1 : instr_q;
  end

  // Performance counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q   <= '0;
      instr_q <= '0;
    end else begin
      cyc_q   <= cyc_d;
      instr_q <= instr_d;
    end
  end

  // Counter outputs, zero while reset is held.
  always_comb begin
    bus.cyc_cnt   = rst ? '0 : cyc_q;
    bus.instr_cnt = rst ? '0 : instr_q;
  end
`endif

endmodule
